// File: rtl/seq_div16_ctrl.sv
// seq_div16_ctrl: sequencing controller for an unsigned restoring divider.
// The subtraction R - D is done by an external shared CPA adder as R + ~D + 1.
// This block owns the remainder/quotient/divisor registers, drives the adder
// operands, and samples the adder after a programmable settle time. It
// produces one quotient bit per iteration.
module seq_div16_ctrl #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  logic [2:0]       state;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic             rmsb;
  logic [BW-1:0]    bitcnt;
  logic [SW-1:0]    setcnt;

  logic             accept;
  logic [WIDTH-1:0] r_next;

  // A set rmsb means the shifted remainder is >= 2^WIDTH > D. In that case the
  // subtraction must succeed even when the adder reports a borrow. The wrapped
  // sum is then the exact new remainder.
  assign accept = add_cout | rmsb;
  assign r_next = accept ? add_s : r;

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign add_a   = r;
  assign add_b   = ~d;
  assign add_cin = 1'b1;

  // Control FSM plus datapath registers; async reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      rmsb        <= 1'b0;
      bitcnt      <= '0;
      setcnt      <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= S_DONE;
            end else begin
              r      <= '0;
              q      <= dividend;
              d      <= divisor;
              bitcnt <= '0;
              state  <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          {rmsb, r, q} <= {r, q, 1'b0};
          setcnt       <= SW'(SETTLE);
          state        <= (SETTLE > 0) ? S_WAIT : S_EVAL;
        end

        S_WAIT: begin
          setcnt <= setcnt - SW'(1);
          if (setcnt == SW'(1)) begin
            state <= S_EVAL;
          end
        end

        S_EVAL: begin
          r    <= r_next;
          q[0] <= accept;
          if (bitcnt == BW'(WIDTH - 1)) begin
            quotient  <= {q[WIDTH-1:1], accept};
            remainder <= r_next;
            state     <= S_DONE;
          end else begin
            bitcnt <= bitcnt + BW'(1);
            state  <= S_SHIFT;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div16_ctrl.sv
// Directed testbench for seq_div16_ctrl. It runs three instances with
// SETTLE = 1, 0 and 3. Each instance is paired with its own behavioural
// 16-bit adder.
module tb_seq_div16_ctrl;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;

  logic [2:0]   st_v;
  logic [2:0]   busy_v;
  logic [2:0]   done_v;
  logic [2:0]   dz_v;
  logic [2:0]   cin_v;
  logic [2:0]   cout_v;
  logic [W-1:0] quo_v [3];
  logic [W-1:0] rem_v [3];
  logic [W-1:0] aa_v  [3];
  logic [W-1:0] ab_v  [3];
  logic [W-1:0] as_v  [3];

  int total = 0;
  int bad   = 0;

  // Behavioural external adders
  for (genvar i = 0; i < 3; i++) begin : g_add
    assign {cout_v[i], as_v[i]} = {1'b0, aa_v[i]} + {1'b0, ab_v[i]} + {{W{1'b0}}, cin_v[i]};
  end

  seq_div16_ctrl #(.WIDTH(W), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .start(st_v[0]), .dividend(dividend), .divisor(divisor),
    .busy(busy_v[0]), .done(done_v[0]), .div_by_zero(dz_v[0]),
    .quotient(quo_v[0]), .remainder(rem_v[0]),
    .add_a(aa_v[0]), .add_b(ab_v[0]), .add_cin(cin_v[0]),
    .add_s(as_v[0]), .add_cout(cout_v[0])
  );

  seq_div16_ctrl #(.WIDTH(W), .SETTLE(0)) u_s0 (
    .clk(clk), .rst(rst), .start(st_v[1]), .dividend(dividend), .divisor(divisor),
    .busy(busy_v[1]), .done(done_v[1]), .div_by_zero(dz_v[1]),
    .quotient(quo_v[1]), .remainder(rem_v[1]),
    .add_a(aa_v[1]), .add_b(ab_v[1]), .add_cin(cin_v[1]),
    .add_s(as_v[1]), .add_cout(cout_v[1])
  );

  seq_div16_ctrl #(.WIDTH(W), .SETTLE(3)) u_s3 (
    .clk(clk), .rst(rst), .start(st_v[2]), .dividend(dividend), .divisor(divisor),
    .busy(busy_v[2]), .done(done_v[2]), .div_by_zero(dz_v[2]),
    .quotient(quo_v[2]), .remainder(rem_v[2]),
    .add_a(aa_v[2]), .add_b(ab_v[2]), .add_cin(cin_v[2]),
    .add_s(as_v[2]), .add_cout(cout_v[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present operands with start; return just after the sampling edge (edge 1)
  task automatic launch(input int sel, input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    st_v[sel] = 1'b1;
    @(posedge clk); #1;
    st_v[sel] = 1'b0;
  endtask

  // Wait for done and check latency and results. With poke set, start is
  // pulsed with junk operands mid-operation and again in the DONE cycle.
  task automatic finish(input int sel, input string tag, input logic [W-1:0] b,
                        input int exp_lat, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic edz, input bit poke);
    int n;
    logic bok;
    logic [W-1:0] nb;
    n   = 1;
    bok = 1'b1;
    nb  = ~b;
    if (b != '0) chk({tag, "_addb"}, ab_v[sel], nb);
    while (!done_v[sel] && n < 300) begin
      bok = bok & busy_v[sel];
      if (poke && n >= 4 && n <= 8) begin
        st_v[sel] = 1'b1;
        dividend  = 16'hFFFF;
        divisor   = 16'h0001;
      end else begin
        st_v[sel] = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_busy_run"}, bok, 1'b1);
    chk({tag, "_busy_done"}, busy_v[sel], 1'b1);
    chk({tag, "_quo"}, quo_v[sel], eq);
    chk({tag, "_rem"}, rem_v[sel], er);
    chk({tag, "_dz"}, dz_v[sel], edz);
    if (poke) begin
      st_v[sel] = 1'b1;
      dividend  = 16'd9;
      divisor   = 16'd3;
    end
    @(posedge clk); #1;
    st_v[sel] = 1'b0;
    chk({tag, "_done_pulse"}, done_v[sel], 1'b0);
    chk({tag, "_idle"}, busy_v[sel], 1'b0);
    chk({tag, "_hold_quo"}, quo_v[sel], eq);
  endtask

  task automatic do_div(input int sel, input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_lat,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    launch(sel, a, b);
    finish(sel, tag, b, exp_lat, eq, er, edz, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    st_v     = '0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_v[0], 1'b0);
    chk("rst_done", done_v[0], 1'b0);
    chk("rst_dz", dz_v[0], 1'b0);
    chk("rst_quo", quo_v[0], 16'h0000);
    chk("rst_rem", rem_v[0], 16'h0000);
    chk("rst_adda", aa_v[0], 16'h0000);
    chk("rst_addb", ab_v[0], 16'hFFFF);
    chk("rst_cin", cin_v[0], 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    do_div(0, "d100_7",     16'd100,  16'd7,    49, 16'd14,   16'd2,    1'b0);
    do_div(0, "dffff_1",    16'hFFFF, 16'h0001, 49, 16'hFFFF, 16'h0000, 1'b0);
    do_div(0, "d8000_ffff", 16'h8000, 16'hFFFF, 49, 16'h0000, 16'h8000, 1'b0);
    do_div(0, "dffff_8001", 16'hFFFF, 16'h8001, 49, 16'h0001, 16'h7FFE, 1'b0);
    do_div(0, "dffff_ffff", 16'hFFFF, 16'hFFFF, 49, 16'h0001, 16'h0000, 1'b0);
    do_div(0, "dz_1234",    16'h1234, 16'h0000, 1,  16'hFFFF, 16'h1234, 1'b1);
    do_div(0, "d9_3",       16'd9,    16'd3,    49, 16'd3,    16'd0,    1'b0);

    // Reset in the middle of an operation, asserted before edge 20
    launch(0, 16'd100, 16'd7);
    repeat (18) @(posedge clk);
    #1;
    chk("mid_busy", busy_v[0], 1'b1);
    chk("mid_hold_quo", quo_v[0], 16'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy_v[0], 1'b0);
    chk("abort_done", done_v[0], 1'b0);
    chk("abort_quo", quo_v[0], 16'h0000);
    chk("abort_rem", rem_v[0], 16'h0000);
    chk("abort_addb", ab_v[0], 16'hFFFF);
    rst = 1'b0;
    @(posedge clk); #1;
    do_div(0, "fresh_100_7", 16'd100, 16'd7, 49, 16'd14, 16'd2, 1'b0);

    // Start pulses while busy and during DONE must be ignored
    launch(0, 16'd100, 16'd7);
    finish(0, "poke_100_7", 16'd7, 49, 16'd14, 16'd2, 1'b0, 1'b1);

    do_div(1, "s0_100_7", 16'd100, 16'd7, 33, 16'd14, 16'd2, 1'b0);
    do_div(2, "s3_100_7", 16'd100, 16'd7, 81, 16'd14, 16'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
